// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte requesters: arbitrate, pulse start, await done, ack.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [8*N_REQ-1:0]   i_data,
    output logic [N_REQ-1:0]     o_ack,
    output logic [N_REQ-1:0]     o_err,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_busy,
    output logic                 o_start,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic [N_REQ-1:0]   ack_reg, ack_next;
    logic [N_REQ-1:0]   err_reg, err_next;
    logic               start_reg, start_next;
    logic               busy_reg, busy_next;
    logic [7:0]         data_reg, data_next;
    logic [IDX_W-1:0]   win_reg, win_next;
    logic [WD_W-1:0]    wd_reg, wd_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;

    logic [7:0]         data_arr [N_REQ];
    logic [IDX_W-1:0]   pick_idx;
    logic [N_REQ-1:0]   pick_oh;
    logic [N_REQ-1:0]   win_oh;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign data_arr[gi] = i_data[8*gi +: 8];
        end
    endgenerate

`ifdef UART_ARB_FIXED_PRIO_EN
    always_comb begin
        pick_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) pick_idx = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0]   last_reg, last_next;
    logic [IDX_W-1:0]   cand;
    logic               rr_found;

    // Search starts just after the previous winner and wraps, so every requester gets a turn.
    always_comb begin
        pick_idx = last_reg;
        cand     = '0;
        rr_found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(last_reg) + i) % N_REQ);
            if (!rr_found && i_req[cand]) begin
                pick_idx = cand;
                rr_found = 1'b1;
            end
        end
    end
`endif

    assign pick_oh = N_REQ'(1) << pick_idx;
    assign win_oh  = N_REQ'(1) << win_reg;

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ack_next   = '0;
        err_next   = '0;
        start_next = 1'b0;
        busy_next  = busy_reg;
        data_next  = data_reg;
        win_next   = win_reg;
        wd_next    = wd_reg;
        gap_next   = gap_reg;
`ifndef UART_ARB_FIXED_PRIO_EN
        last_next  = last_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|i_req) begin
                    win_next   = pick_idx;
                    grant_next = pick_oh;
                    data_next  = data_arr[pick_idx];
                    busy_next  = 1'b1;
                    start_next = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                wd_next    = '0;
                state_next = WAIT;
            end
            WAIT: begin
                wd_next = wd_reg + 1'b1;
                // A done arriving on the timeout edge still counts as success.
                if (i_tx_done || wd_reg == WD_LAST) begin
                    if (i_tx_done) ack_next = win_oh;
                    else           err_next = win_oh;
`ifndef UART_ARB_FIXED_PRIO_EN
                    last_next  = win_reg;
`endif
                    grant_next = '0;
                    gap_next   = '0;
                    if (GAP_CYCLES == 0) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end else begin
                        state_next = GAP;
                    end
                end
            end
            GAP: begin
                gap_next = gap_reg + 1'b1;
                if (gap_reg == GAP_LAST) begin
                    state_next = IDLE;
                    busy_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            ack_reg   <= '0;
            err_reg   <= '0;
            start_reg <= 1'b0;
            busy_reg  <= 1'b0;
            data_reg  <= '0;
            win_reg   <= '0;
            wd_reg    <= '0;
            gap_reg   <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
            last_reg  <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            start_reg <= start_next;
            busy_reg  <= busy_next;
            data_reg  <= data_next;
            win_reg   <= win_next;
            wd_reg    <= wd_next;
            gap_reg   <= gap_next;
`ifndef UART_ARB_FIXED_PRIO_EN
            last_reg  <= last_next;
`endif
        end
    end

    assign o_ack     = ack_reg;
    assign o_err     = err_reg;
    assign o_grant   = grant_reg;
    assign o_busy    = busy_reg;
    assign o_start   = start_reg;
    assign o_tx_data = data_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of transactions plus reset/spurious-done sequences.
// Expectations follow UART_ARB_FIXED_PRIO_EN when that macro is defined.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  i_req;
    logic [31:0] i_data;
    logic [3:0]  o_ack, o_err, o_grant;
    logic        o_busy, o_start, i_tx_done;
    logic [7:0]  o_tx_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          dly;       // negative: never send done
        logic        drop;      // release i_req right after grant
        logic [3:0]  exp_oh;
        logic [7:0]  exp_byte;
    } rec_t;

    rec_t tbl [10];

    uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(50)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_data    (i_data),
        .o_ack     (o_ack),
        .o_err     (o_err),
        .o_grant   (o_grant),
        .o_busy    (o_busy),
        .o_start   (o_start),
        .o_tx_data (o_tx_data),
        .i_tx_done (i_tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int n, input rec_t r);
        int  lat;
        logic premature;
        i_req  = r.req;
        i_data = r.data;
        tick();
        check("start_latency", {31'd0, o_start}, 32'd1);
        check("grant", {28'd0, o_grant}, {28'd0, r.exp_oh});
        check("tx_data", {24'd0, o_tx_data}, {24'd0, r.exp_byte});
        check("busy_start", {31'd0, o_busy}, 32'd1);
        if (r.drop) i_req = 4'b0000;
        tick();
        check("start_width", {31'd0, o_start}, 32'd0);
        if (r.dly >= 0) begin
            premature = 1'b0;
            for (int k = 0; k < r.dly; k++) begin
                tick();
                if (o_ack != 4'd0 || o_err != 4'd0) premature = 1'b1;
            end
            check("no_early_pulse", {31'd0, premature}, 32'd0);
            i_tx_done = 1'b1;
            tick();
            i_tx_done = 1'b0;
            check("ack", {28'd0, o_ack}, {28'd0, r.exp_oh});
            check("no_err", {28'd0, o_err}, 32'd0);
        end else begin
            lat = 0;
            for (int k = 1; k <= 60; k++) begin
                tick();
                if (o_err != 4'd0 || o_ack != 4'd0) begin
                    lat = k;
                    break;
                end
            end
            check("timeout_latency", lat, 32'd50);
            check("err", {28'd0, o_err}, {28'd0, r.exp_oh});
            check("no_ack", {28'd0, o_ack}, 32'd0);
        end
        check("gap_grant", {28'd0, o_grant}, 32'd0);
        check("gap_data_hold", {24'd0, o_tx_data}, {24'd0, r.exp_byte});
        tick();
        check("pulse_width", {24'd0, o_ack, o_err}, 32'd0);
        check("gap_busy", {31'd0, o_busy}, 32'd1);
        tick();
        check("idle_after_gap", {31'd0, o_busy}, 32'd0);
        $display("txn %0d req=%b grant=%b byte=%h dly=%0d", n, r.req, r.exp_oh, r.exp_byte, r.dly);
    endtask

    initial begin
        rec_t rr;
`ifdef UART_ARB_FIXED_PRIO_EN
        tbl[0] = '{4'b1010, 32'hB000A100, 3,  1'b0, 4'b0010, 8'hA1};
        tbl[1] = '{4'b1010, 32'hB000A100, 0,  1'b0, 4'b0010, 8'hA1};
        tbl[2] = '{4'b1010, 32'hB000A100, 5,  1'b0, 4'b0010, 8'hA1};
        tbl[3] = '{4'b0001, 32'h000000A3, 20, 1'b0, 4'b0001, 8'hA3};
        tbl[4] = '{4'b0100, 32'h005A0000, -1, 1'b0, 4'b0100, 8'h5A};
        tbl[5] = '{4'b1111, 32'h43322110, 2,  1'b0, 4'b0001, 8'h10};
        tbl[6] = '{4'b1000, 32'h43322110, 1,  1'b0, 4'b1000, 8'h43};
        tbl[7] = '{4'b0010, 32'h0000C700, 49, 1'b1, 4'b0010, 8'hC7};
        tbl[8] = '{4'b0110, 32'h00E4D200, 4,  1'b0, 4'b0010, 8'hD2};
        tbl[9] = '{4'b1100, 32'h9BE4D200, 2,  1'b0, 4'b0100, 8'hE4};
`else
        tbl[0] = '{4'b1111, 32'h43322110, 3,  1'b0, 4'b0001, 8'h10};
        tbl[1] = '{4'b1111, 32'h43322110, 5,  1'b0, 4'b0010, 8'h21};
        tbl[2] = '{4'b1111, 32'h43322110, 0,  1'b0, 4'b0100, 8'h32};
        tbl[3] = '{4'b1111, 32'h43322110, 1,  1'b0, 4'b1000, 8'h43};
        tbl[4] = '{4'b1111, 32'h43322110, 2,  1'b0, 4'b0001, 8'h10};
        tbl[5] = '{4'b0001, 32'h000000A3, 20, 1'b0, 4'b0001, 8'hA3};
        tbl[6] = '{4'b0100, 32'h005A0000, -1, 1'b0, 4'b0100, 8'h5A};
        tbl[7] = '{4'b1111, 32'h43322110, 2,  1'b0, 4'b1000, 8'h43};
        tbl[8] = '{4'b0010, 32'h0000C700, 49, 1'b1, 4'b0010, 8'hC7};
        tbl[9] = '{4'b0110, 32'h00E4D200, 4,  1'b0, 4'b0100, 8'hE4};
`endif
        reset     = 1'b0;
        i_req     = 4'b0000;
        i_data    = 32'd0;
        i_tx_done = 1'b0;
        tick();
        tick();
        check("reset_outputs", {o_ack, o_err, o_grant, o_busy, o_start, o_tx_data}, 32'd0);
        reset = 1'b1;
        tick();
        check("idle_after_reset", {31'd0, o_busy}, 32'd0);

        for (int n = 0; n < 10; n++) run_txn(n, tbl[n]);

        // Done pulse while idle must be ignored.
        i_req     = 4'b0000;
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check("spurious_ack", {28'd0, o_ack}, 32'd0);
        check("spurious_busy", {30'd0, o_busy, o_start}, 32'd0);
        tick();
        check("spurious_idle", {28'd0, o_grant}, 32'd0);
        $display("txn spurious_done in IDLE");

        // Reset in the middle of WAIT clears everything immediately.
        i_req  = 4'b0001;
        i_data = 32'h000000A3;
        tick();
        check("mid_start", {31'd0, o_start}, 32'd1);
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {o_ack, o_err, o_grant, o_busy, o_start, o_tx_data}, 32'd0);
        i_req = 4'b0000;
        tick();
        tick();
        check("reset_no_pulse", {24'd0, o_ack, o_err}, 32'd0);
        reset = 1'b1;
        $display("txn reset_mid_wait");
        rr = '{4'b1000, 32'h43322110, 2, 1'b0, 4'b1000, 8'h43};
        run_txn(10, rr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
